led_cmd_ind: RTL and testbench
==============================

LED_CMD_IND -- requirements
Module: led_cmd_ind

Interface
REQ-001 Parameter HOLD_TICKS, default 8: ticks one command group stays displayed before switching to the other (range 1..255).
REQ-002 Parameter STRETCH_TICKS, default 4: minimum ticks a command bit stays lit after its input drops (range 1..7).
REQ-003 clk  in  1  single system clock, the same clock that drives the clock divider.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tick_src  in  1  slow divided square wave (divider tap, e.g. div256), synchronous to clk.
REQ-006 com_prd  in  8  transmitter command bits, active-high, level.
REQ-007 com_prm  in  8  receiver command bits, active-high, level.
REQ-008 led  out  8  registered command LED drive, active-high.
REQ-009 led_prd  out  1  registered group select: 1 = transmitter group on led, 0 = receiver group.

Function
REQ-010 Tick: tick_src is registered every cycle; tick = tick_src & ~tick_src_q, a one-clk pulse per tick_src rising edge; falling edges and constant levels produce no tick.
REQ-011 Stretch: each of the 16 command bits has a 3-bit counter; raw bit high reloads STRETCH_TICKS every cycle; otherwise the counter decrements by 1 on tick while nonzero, and saturates at 0.
REQ-012 Stretched bit = raw bit OR counter nonzero; act_prd = OR of stretched com_prd, act_prm = OR of stretched com_prm.
REQ-013 FSM states IDLE, SHOW_PRD, SHOW_PRM; state and the 8-bit hold counter hcnt are registered.
REQ-014 IDLE: act_prd -> SHOW_PRD; else act_prm -> SHOW_PRM; else stay; transitions take effect next clk, with or without a tick; hcnt cleared on entry to any state.
REQ-015 SHOW_PRD: neither active -> IDLE; act_prd=0 and act_prm=1 -> SHOW_PRM immediately; both active -> hcnt increments on tick, and on the tick where hcnt = HOLD_TICKS-1 goes to SHOW_PRM.
REQ-016 SHOW_PRM: symmetric to REQ-015 with the groups swapped.
REQ-017 Simultaneous first activation of both groups from IDLE -> SHOW_PRD (transmitter priority).
REQ-018 led = stretched bits of the displayed group, registered; IDLE -> led = 0; latency raw bit rise -> led = 1 clk when the group is already displayed.
REQ-019 led_prd = 1 in IDLE and SHOW_PRD, 0 in SHOW_PRM, registered with led and updated on the same cycle.
REQ-020 Command edges coinciding with a tick: the reload of REQ-011 takes priority over the decrement.

Reset
REQ-021 While rst=1: state=IDLE, hcnt=0, all stretch counters=0, led=8'h00, led_prd=1.
REQ-022 While rst=1, tick_src_q loads tick_src so that no spurious tick occurs on the first cycle after reset.
REQ-023 Reset asserted mid-display overrides all activity on the next clk edge; commands held high through reset release show on led 2 clk after release.

Configuration
REQ-024 Macro LED_CMD_IND_BLINK_EN.
REQ-025 Defined: a phase flop toggles on every tick (reset 0); a displayed bit that is only stretched (raw bit low, counter nonzero) is gated by the phase flop; bits with raw input high stay steady.
REQ-026 Not defined: no phase flop is present, and stretched bits are lit steadily.

Verification
REQ-027 rst=1 for 3 clk with tick_src=1, then released -> led=00, led_prd=1, and no tick on the first clk after release.
REQ-028 com_prd=8'h05 for 1 clk, tick every 256 clk, STRETCH_TICKS=4 -> led=05, led_prd=1 from the next clk until the 4th tick after the command drops, then led=00 and IDLE.
REQ-029 com_prd=8'h01 and com_prm=8'h80 both held, HOLD_TICKS=8 -> led alternates 01/80 and led_prd alternates 1/0, switching every 8 ticks, starting with 01.
REQ-030 In SHOW_PRD with com_prm=8'h10 held, com_prd drops and its stretch expires -> SHOW_PRM on the next clk, led=10, led_prd=0, with no wait for hcnt.
REQ-031 com_prm=8'h02 raised on the same clk as a tick while its counter=1 -> counter reloads to 4 and the bit stays lit.
REQ-032 With BLINK_EN, com_prd=8'h08 pulsed then released -> bit 3 toggles each tick for 4 ticks and then stays 0; without BLINK_EN, bit 3 is steady 1 for 4 ticks.

Source files
------------

// File: rtl/led_cmd_ind_if.sv
// Command/LED bundle between the command sources and the LED indicator block.
// Master drives the tick tap and command levels; slave drives the LED outputs.
interface led_cmd_ind_if;
   logic       tick_src;
   logic [7:0] com_prd;
   logic [7:0] com_prm;
   logic [7:0] led;
   logic       led_prd;

   modport master (output tick_src, com_prd, com_prm, input led, led_prd);
   modport slave  (input tick_src, com_prd, com_prm, output led, led_prd);
endinterface

// File: rtl/led_cmd_ind.sv
// Pulse-stretched command LEDs, time-shared between transmitter and receiver groups; led 1 clk after a displayed bit rises.
// No backpressure (pure level inputs). LED_CMD_IND_BLINK_EN makes stretch-only bits blink on the tick phase.
module led_cmd_ind #(
   parameter int HOLD_TICKS    = 8,
   parameter int STRETCH_TICKS = 4
) (
   input  logic         clk,
   input  logic         rst,
   led_cmd_ind_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHOW_PRD, SHOW_PRM} state_t;

   localparam logic [2:0] STRETCH_LD = 3'(STRETCH_TICKS);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);

   logic        tick_src_q;
   logic        tick;
   logic [15:0] raw;
   logic [2:0]  scnt [16];
   logic [15:0] lit;
   logic [15:0] show;
   logic        act_prd;
   logic        act_prm;
   state_t      state;
   logic [7:0]  hcnt;

   assign raw  = {bus.com_prm, bus.com_prd};
   assign tick = bus.tick_src & ~tick_src_q;

   // Loaded through reset as well, so a high tap at release is not seen as an edge.
   always_ff @(posedge clk) begin
      tick_src_q <= bus.tick_src;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (rst) begin
            scnt[i] <= 3'd0;
         end else if (raw[i]) begin
            scnt[i] <= STRETCH_LD;
         end else if (tick && (scnt[i] != 3'd0)) begin
            scnt[i] <= scnt[i] - 3'd1;
         end
      end
   end

`ifdef LED_CMD_IND_BLINK_EN
   logic phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= 1'b0;
      end else if (tick) begin
         phase <= ~phase;
      end
   end
`endif

   always_comb begin
      lit  = '0;
      show = '0;
      for (int i = 0; i < 16; i++) begin
         lit[i] = raw[i] | (scnt[i] != 3'd0);
`ifdef LED_CMD_IND_BLINK_EN
         show[i] = raw[i] | ((scnt[i] != 3'd0) & phase);
`else
         show[i] = lit[i];
`endif
      end
   end

   assign act_prd = |lit[7:0];
   assign act_prm = |lit[15:8];

   // led follows the group displayed in the current state, so a state change shows one clk later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hcnt        <= 8'd0;
         bus.led     <= 8'h00;
         bus.led_prd <= 1'b1;
      end else begin
         bus.led_prd <= (state != SHOW_PRM);
         case (state)
            IDLE: begin
               bus.led <= 8'h00;
               hcnt    <= 8'd0;
               if (act_prd) begin
                  state <= SHOW_PRD;
               end else if (act_prm) begin
                  state <= SHOW_PRM;
               end
            end
            SHOW_PRD: begin
               bus.led <= show[7:0];
               if (!act_prd) begin
                  hcnt  <= 8'd0;
                  state <= act_prm ? SHOW_PRM : IDLE;
               end else if (!act_prm) begin
                  hcnt <= 8'd0;
               end else if (tick) begin
                  if (hcnt == HOLD_LAST) begin
                     hcnt  <= 8'd0;
                     state <= SHOW_PRM;
                  end else begin
                     hcnt <= hcnt + 8'd1;
                  end
               end
            end
            SHOW_PRM: begin
               bus.led <= show[15:8];
               if (!act_prm) begin
                  hcnt  <= 8'd0;
                  state <= act_prd ? SHOW_PRD : IDLE;
               end else if (!act_prd) begin
                  hcnt <= 8'd0;
               end else if (tick) begin
                  if (hcnt == HOLD_LAST) begin
                     hcnt  <= 8'd0;
                     state <= SHOW_PRD;
                  end else begin
                     hcnt <= hcnt + 8'd1;
                  end
               end
            end
            default: begin
               bus.led <= 8'h00;
               hcnt    <= 8'd0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_led_cmd_ind.sv
// Bench for led_cmd_ind: directed scenarios, per-cycle comparison against a group/stretch model.
module tb_led_cmd_ind;
   localparam int HOLD = 8;
   localparam int STR  = 4;
`ifdef LED_CMD_IND_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   led_cmd_ind_if bus();

   led_cmd_ind #(.HOLD_TICKS(HOLD), .STRETCH_TICKS(STR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   rem [16];      // ticks of stretch left per command bit
   int   disp;          // 0 = nothing shown, 1 = transmitter group, 2 = receiver group
   int   held;          // ticks spent sharing the display with the other group
   bit   m_phase;
   logic m_tsq;
   logic [7:0] m_led;
   logic m_led_prd;
   int   n_ticks;
   bit   tick_auto;
   int   tper;
   int   tdiv;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [15:0] raw;
      logic [7:0]  nl;
      bit tk, ap, am, own, oth;
      int j;
      raw = {bus.com_prm, bus.com_prd};
      tk  = bus.tick_src && !m_tsq;
      m_tsq = bus.tick_src;
      if (rst) begin
         for (int i = 0; i < 16; i++) rem[i] = 0;
         disp = 0; held = 0; m_phase = 1'b0;
         m_led = 8'h00; m_led_prd = 1'b1;
         return;
      end
      if (tk) n_ticks++;
      ap = 1'b0; am = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ap = ap | raw[i]     | (rem[i] > 0);
         am = am | raw[i + 8] | (rem[i + 8] > 0);
      end
      nl = 8'h00;
      if (disp != 0) begin
         for (int i = 0; i < 8; i++) begin
            j = (disp == 1) ? i : i + 8;
            nl[i] = raw[j] | ((rem[j] > 0) & (!BLINK | m_phase));
         end
      end
      m_led     = nl;
      m_led_prd = (disp != 2);
      if (disp == 0) begin
         disp = ap ? 1 : (am ? 2 : 0);
         held = 0;
      end else begin
         own = (disp == 1) ? ap : am;
         oth = (disp == 1) ? am : ap;
         if (!own) begin
            disp = oth ? 3 - disp : 0;
            held = 0;
         end else if (!oth) begin
            held = 0;
         end else if (tk) begin
            held++;
            if (held == HOLD) begin
               disp = 3 - disp;
               held = 0;
            end
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (raw[i]) rem[i] = STR;
         else if (tk && rem[i] > 0) rem[i] = rem[i] - 1;
      end
      if (tk) m_phase = !m_phase;
   endtask

   task automatic cyc();
      if (tick_auto) begin
         bus.tick_src = ((tdiv % tper) >= (tper / 2));
         tdiv++;
      end
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("led", bus.led, m_led);
      chk("led_prd", 8'(bus.led_prd), 8'(m_led_prd));
   endtask

   task automatic wait_to(input int target, input int budget);
      int k;
      k = 0;
      while (n_ticks < target && k < budget) begin
         cyc();
         k++;
      end
      if (n_ticks < target) begin
         checks++;
         errors++;
         $display("FAIL tick_wait: reached %0d ticks, wanted %0d", n_ticks, target);
      end
   endtask

   task automatic tpulse();
      bus.tick_src = 1'b1;
      cyc();
      cyc();
      bus.tick_src = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [7:0] l1, l2;
      for (int i = 0; i < 16; i++) rem[i] = 0;
      disp = 0; held = 0; m_phase = 1'b0; m_tsq = 1'b0;
      m_led = 8'h00; m_led_prd = 1'b1; n_ticks = 0;
      tick_auto = 1'b0; tper = 16; tdiv = 0;

      // Reset with the tap high and commands held through release.
      rst = 1'b1; bus.tick_src = 1'b1; bus.com_prd = 8'h05; bus.com_prm = 8'h00;
      repeat (3) cyc();
      chk("rst_led", bus.led, 8'h00);
      chk("rst_led_prd", 8'(bus.led_prd), 8'd1);
      rst = 1'b0;
      cyc();
      chk("rel_led_1clk", bus.led, 8'h00);
      cyc();
      chk("rel_led_2clk", bus.led, 8'h05);
      chk("rel_led_prd", 8'(bus.led_prd), 8'd1);

      // Let the transmitter group expire back to idle.
      bus.com_prd = 8'h00; tick_auto = 1'b1; tper = 16;
      wait_to(n_ticks + STR + 1, 500);
      repeat (2) cyc();
      chk("expire_led", bus.led, 8'h00);
      chk("expire_led_prd", 8'(bus.led_prd), 8'd1);

      // One-clk transmitter pulse with a slow tick.
      tper = 256;
      bus.com_prd = 8'h05;
      cyc();
      base = n_ticks;
      bus.com_prd = 8'h00;
      cyc();
`ifndef LED_CMD_IND_BLINK_EN
      chk("pulse_led_lit", bus.led, 8'h05);
`endif
      wait_to(base + STR - 1, 2000);
`ifndef LED_CMD_IND_BLINK_EN
      chk("pulse_led_3tick", bus.led, 8'h05);
`endif
      wait_to(base + STR, 2000);
      cyc();
      chk("pulse_led_off", bus.led, 8'h00);
      chk("pulse_led_prd", 8'(bus.led_prd), 8'd1);

      // Both groups held: alternation every HOLD ticks, transmitter first.
      tper = 16;
      bus.com_prd = 8'h01; bus.com_prm = 8'h80;
      cyc();
      base = n_ticks;
      cyc();
      chk("alt_first_led", bus.led, 8'h01);
      chk("alt_first_prd", 8'(bus.led_prd), 8'd1);
      wait_to(base + HOLD, 1000);
      cyc();
      chk("alt_second_led", bus.led, 8'h80);
      chk("alt_second_prd", 8'(bus.led_prd), 8'd0);
      wait_to(base + 2 * HOLD, 1000);
      cyc();
      chk("alt_third_led", bus.led, 8'h01);
      chk("alt_third_prd", 8'(bus.led_prd), 8'd1);

      // Transmitter drops while displayed: receiver takes over once stretch expires.
      bus.com_prd = 8'h00; bus.com_prm = 8'h10;
      base = n_ticks;
      wait_to(base + STR, 1000);
      cyc();
      cyc();
      chk("handover_led", bus.led, 8'h10);
      chk("handover_prd", 8'(bus.led_prd), 8'd0);

      // Reset in the middle of a display, commands held through it.
      rst = 1'b1;
      cyc();
      chk("midrst_led", bus.led, 8'h00);
      chk("midrst_prd", 8'(bus.led_prd), 8'd1);
      rst = 1'b0;
      cyc();
      chk("midrel_led_1clk", bus.led, 8'h00);
      cyc();
      chk("midrel_led_2clk", bus.led, 8'h10);
      chk("midrel_prd_2clk", 8'(bus.led_prd), 8'd0);

      // Reload wins over a coinciding tick.
      tick_auto = 1'b0; bus.tick_src = 1'b0;
      bus.com_prm = 8'h02;
      cyc();
      bus.com_prm = 8'h00;
      repeat (STR - 1) tpulse();
      bus.com_prm = 8'h02; bus.tick_src = 1'b1;
      cyc();
      bus.com_prm = 8'h00;
      cyc();
      bus.tick_src = 1'b0;
      cyc();
      cyc();
      repeat (STR - 1) tpulse();
      chk("reload_still_shown", 8'(bus.led_prd), 8'd0);
`ifndef LED_CMD_IND_BLINK_EN
      chk("reload_led", bus.led, 8'h02);
`endif
      tpulse();
      chk("reload_expired_led", bus.led, 8'h00);
      chk("reload_expired_prd", 8'(bus.led_prd), 8'd1);

      // Stretch-only bit: steady, or blinking with the tick phase.
      bus.com_prd = 8'h08;
      cyc();
      bus.com_prd = 8'h00;
      tpulse();
      l1 = bus.led;
      tpulse();
      l2 = bus.led;
`ifdef LED_CMD_IND_BLINK_EN
      chk("blink_toggle", l1 ^ l2, 8'h08);
`else
      chk("steady_1", l1, 8'h08);
      chk("steady_2", l2, 8'h08);
`endif
      tpulse();
      tpulse();
      chk("stretch_done_led", bus.led, 8'h00);
      chk("stretch_done_prd", 8'(bus.led_prd), 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
